// File: rtl/outport_scheduler.sv
// Output-port wormhole scheduler: round-robin grant with 1-cycle arbitration latency, then the lock is held until the tail flit.
// Flits from the owner are acked only when downstream credits remain; a stalled owner keeps the lock.
module outport_scheduler #(
  parameter int PORTS   = 5,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [PORTS-1:0] port_rqs_i,
  input  logic             flit_tail_i,
  input  logic             credit_in_i,
  output logic [PORTS-1:0] arb_ack_o,
  output logic [PORTS-1:0] xbar_cfg_vector_o,
  output logic [CNT_W-1:0] credit_cnt_o,
  output logic             busy_o,
  output logic             credit_err_o
);

  localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] credit_q, credit_d;
  logic             err_q, err_d;

  logic [PTR_W-1:0] winner;
  logic             found;
  logic [PORTS-1:0] owner_oh;
  logic             locked;
  logic             xfer;
  logic [PTR_W-1:0] next_ptr;

  // First requester at or after rr_ptr, wrapping around the port list.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < PORTS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!found && port_rqs_i[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  assign locked   = (state_q == ST_LOCKED);
  assign xfer     = locked && port_rqs_i[owner_q] && (credit_q != '0);
  assign next_ptr = (owner_q == PTR_W'(PORTS - 1)) ? '0 : owner_q + PTR_W'(1);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (!locked) begin
      if (found) begin
        owner_d = winner;
        state_d = ST_LOCKED;
      end
    end else if (xfer && flit_tail_i) begin
      state_d  = ST_IDLE;
      rr_ptr_d = next_ptr;
    end
  end

  // A simultaneous send and return leaves the count unchanged.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (xfer && !credit_in_i) begin
      credit_d = credit_q - CNT_W'(1);
    end else if (credit_in_i && !xfer) begin
      if (credit_q == CRED_MAX) err_d = 1'b1;
      else                      credit_d = credit_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      credit_q <= CRED_MAX;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign arb_ack_o         = xfer ? owner_oh : '0;
  assign xbar_cfg_vector_o = locked ? owner_oh : '0;
  assign credit_cnt_o      = credit_q;
  assign busy_o            = locked;
  assign credit_err_o      = err_q;

endmodule
